mdu_iterative: RTL and testbench

Iterative multiply/divide unit in the EX stage. It executes MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers. It feeds the hazard unit a registered busy flag, which the hazard unit uses to stall MFHI/MFLO and back-to-back MDU instructions in D. Multiply and divide are both radix-2 shift-and-add/subtract over DATA_WIDTH cycles.

---
 rtl/mdu_iterative.sv | 238 +++++++++++++++++++++++
 tb/tb_mdu_iterative.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit with the architectural HI/LO registers.
// Multiply is radix-2 shift-and-add. Divide is radix-2 restoring. Both take
// DATA_WIDTH iteration cycles followed by one sign-fix cycle.
// A busy flag is exported for the hazard unit.
// Optional feature macro: MDU_DIV_EN. When it is undefined, the divider
// datapath is removed and DIV/DIVU are accepted as no-ops.
module mdu_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [2:0]            i_op,
  input  logic [DATA_WIDTH-1:0] i_src_a,
  input  logic [DATA_WIDTH-1:0] i_src_b,
  input  logic                  i_abort,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_hi,
  output logic [DATA_WIDTH-1:0] o_lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] ONES_W   = {DATA_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0]  CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t                state;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] acc_hi;   // P for multiply, R for divide
  logic [DATA_WIDTH-1:0] acc_lo;   // Q (multiplier / quotient)
  logic [DATA_WIDTH-1:0] opnd;     // multiplicand or divisor magnitude
  logic                  neg_q;    // negate product or quotient in FIX

  logic [DATA_WIDTH:0]   mul_sum;
  logic [DATA_WIDTH-1:0] mul_hi_nx;
  logic [DATA_WIDTH-1:0] mul_lo_nx;
  logic [2*DATA_WIDTH-1:0] prod_raw;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0] fix_hi;
  logic [DATA_WIDTH-1:0] fix_lo;

`ifdef MDU_DIV_EN
  logic                  is_div;
  logic                  neg_r;    // remainder takes the dividend's sign
  logic                  div_zero;
  logic [DATA_WIDTH:0]   div_shift;
  logic [DATA_WIDTH-1:0] div_trial;
  logic [DATA_WIDTH-1:0] div_hi_nx;
  logic [DATA_WIDTH-1:0] div_lo_nx;
`endif

  // Magnitude of an operand; unsigned ops pass the raw value through.
  function automatic logic [DATA_WIDTH-1:0] abs_val(input logic [DATA_WIDTH-1:0] v,
                                                    input logic is_signed);
    if (is_signed && v[DATA_WIDTH-1]) begin
      abs_val = -v;
    end else begin
      abs_val = v;
    end
  endfunction

  // One shift-and-add multiply step: conditional add with carry, then shift right.
  always_comb begin
    if (acc_lo[0]) begin
      mul_sum = {1'b0, acc_hi} + {1'b0, opnd};
    end else begin
      mul_sum = {1'b0, acc_hi};
    end
    mul_hi_nx = mul_sum[DATA_WIDTH:1];
    mul_lo_nx = {mul_sum[0], acc_lo[DATA_WIDTH-1:1]};
  end

`ifdef MDU_DIV_EN
  // One restoring divide step: shift {R,Q} left, keep R-divisor when it is non-negative.
  always_comb begin
    div_shift = {acc_hi, acc_lo[DATA_WIDTH-1]};
    div_trial = div_shift[DATA_WIDTH-1:0] - opnd;
    div_lo_nx = {acc_lo[DATA_WIDTH-2:0], 1'b0};
    if (div_shift >= {1'b0, opnd}) begin
      div_hi_nx    = div_trial;
      div_lo_nx[0] = 1'b1;
    end else begin
      div_hi_nx    = div_shift[DATA_WIDTH-1:0];
      div_lo_nx[0] = 1'b0;
    end
  end
`endif

  // Sign correction of the finished result and HI/LO selection for the FIX write.
  always_comb begin
    prod_raw = {acc_hi, acc_lo};
    if (neg_q) begin
      prod_fix = -prod_raw;
    end else begin
      prod_fix = prod_raw;
    end
    fix_hi = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    fix_lo = prod_fix[DATA_WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (is_div) begin
      // Quotient magnitude is all ones for a zero divisor; force it so the
      // sign fix cannot disturb it. The remainder already equals the dividend.
      if (div_zero) begin
        fix_lo = ONES_W;
      end else if (neg_q) begin
        fix_lo = -acc_lo;
      end else begin
        fix_lo = acc_lo;
      end
      if (neg_r) begin
        fix_hi = -acc_hi;
      end else begin
        fix_hi = acc_hi;
      end
    end else begin
      fix_hi = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
      fix_lo = prod_fix[DATA_WIDTH-1:0];
    end
`endif
  end

  // Control FSM, iteration datapath and registered HI/LO/busy/done outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= ST_IDLE;
      cnt    <= CNT_ZERO;
      acc_hi <= ZERO_W;
      acc_lo <= ZERO_W;
      opnd   <= ZERO_W;
      neg_q  <= 1'b0;
`ifdef MDU_DIV_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
`endif
      o_busy <= 1'b0;
      o_done <= 1'b0;
      o_hi   <= ZERO_W;
      o_lo   <= ZERO_W;
    end else begin
      o_done <= 1'b0;
      if (i_abort) begin
        state  <= ST_IDLE;
        o_busy <= 1'b0;
        cnt    <= CNT_ZERO;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              case (i_op)
                OP_MULT, OP_MULTU: begin
                  state  <= ST_CALC;
                  o_busy <= 1'b1;
                  cnt    <= CNT_ZERO;
                  acc_hi <= ZERO_W;
                  acc_lo <= abs_val(i_src_b, i_op == OP_MULT);
                  opnd   <= abs_val(i_src_a, i_op == OP_MULT);
                  neg_q  <= (i_op == OP_MULT) & (i_src_a[DATA_WIDTH-1] ^ i_src_b[DATA_WIDTH-1]);
`ifdef MDU_DIV_EN
                  is_div <= 1'b0;
`endif
                end
`ifdef MDU_DIV_EN
                OP_DIV, OP_DIVU: begin
                  state    <= ST_CALC;
                  o_busy   <= 1'b1;
                  cnt      <= CNT_ZERO;
                  acc_hi   <= ZERO_W;
                  acc_lo   <= abs_val(i_src_a, i_op == OP_DIV);
                  opnd     <= abs_val(i_src_b, i_op == OP_DIV);
                  neg_q    <= (i_op == OP_DIV) & (i_src_a[DATA_WIDTH-1] ^ i_src_b[DATA_WIDTH-1]);
                  neg_r    <= (i_op == OP_DIV) & i_src_a[DATA_WIDTH-1];
                  div_zero <= (i_src_b == ZERO_W);
                  is_div   <= 1'b1;
                end
`endif
                OP_MTHI: o_hi <= i_src_a;
                OP_MTLO: o_lo <= i_src_a;
                default: begin
                end
              endcase
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_CALC: begin
`ifdef MDU_DIV_EN
            if (is_div) begin
              acc_hi <= div_hi_nx;
              acc_lo <= div_lo_nx;
            end else begin
              acc_hi <= mul_hi_nx;
              acc_lo <= mul_lo_nx;
            end
`else
            acc_hi <= mul_hi_nx;
            acc_lo <= mul_lo_nx;
`endif
            if (cnt == CNT_LAST) begin
              state <= ST_FIX;
              cnt   <= CNT_ZERO;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_FIX: begin
            o_hi   <= fix_hi;
            o_lo   <= fix_lo;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
          default: begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative: an arithmetic reference model with a
// per-cycle compare process, plus directed vectors with literal expectations.
// Honours MDU_DIV_EN the same way the design does.
module tb_mdu_iterative;

  localparam int DW = 32;
`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd7;
  logic [DW-1:0] src_a = '0;
  logic [DW-1:0] src_b = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic          done;
  logic [DW-1:0] hi;
  logic [DW-1:0] lo;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  logic [DW-1:0] m_hi = '0;
  logic [DW-1:0] m_lo = '0;
  logic [63:0]   m_pend = '0;
  int            m_left = 0;

  mdu_iterative #(.DATA_WIDTH(DW), .CNT_WIDTH(5)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_src_a(src_a), .i_src_b(src_b), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_long(input logic [2:0] o);
    return (o == 3'd0) || (o == 3'd1) || (DIV_EN && ((o == 3'd2) || (o == 3'd3)));
  endfunction

  // {HI, LO} from plain integer arithmetic
  function automatic logic [63:0] model_result(input logic [2:0] o, input logic [DW-1:0] a,
                                               input logic [DW-1:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    int              ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      3'd0: begin sp = sa * sb; return sp; end
      3'd1: begin up = ua * ub; return up; end
      3'd2: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'd0, 32'h80000000};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      3'd3: begin
        if (b == 32'd0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
      default: return 64'd0;
    endcase
  endfunction

  // cycle-level reference: countdown from issue to result visibility
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (abort) begin
        m_busy <= 1'b0;
        m_left <= 0;
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_busy <= 1'b0; m_done <= 1'b1; m_left <= 0;
          m_hi <= m_pend[63:32]; m_lo <= m_pend[31:0];
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        if (is_long(op)) begin
          m_busy <= 1'b1;
          m_left <= DW + 1;
          m_pend <= model_result(op, src_a, src_b);
        end else if (op == 3'd4) begin
          m_hi <= src_a;
        end else if (op == 3'd5) begin
          m_lo <= src_a;
        end
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
    chk("cyc_done", {31'd0, done}, {31'd0, m_done});
    chk("cyc_hi", hi, m_hi);
    chk("cyc_lo", lo, m_lo);
  end

  // called on a negedge; returns on the negedge of cycle t+1
  task automatic issue(input logic [2:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = 3'd7;
  endtask

  // bounded wait for o_done; returns on the negedge of the done cycle
  task automatic wait_done(input string name, output int busy_cycles);
    int n;
    n = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      n++;
    end
    chk({name, "_done_seen"}, {31'd0, done}, 32'd1);
  endtask

  task automatic run(input string name, input logic [2:0] o, input logic [DW-1:0] a,
                     input logic [DW-1:0] b);
    int bc;
    issue(o, a, b);
    if (is_long(o)) wait_done(name, bc);
  endtask

  initial begin
    int bc;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU max*max, with latency measurement
    issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("multu_max", bc);
    chk("multu_busy_cycles", bc, 32'd33);
    chk("multu_max_hi", hi, 32'hFFFFFFFE);
    chk("multu_max_lo", lo, 32'h00000001);

    // MULT -3*7, then DIV -7/2 issued in the done cycle
    issue(3'd0, 32'hFFFFFFFD, 32'd7);
    wait_done("mult_m3_7", bc);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFEB);
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
`ifdef MDU_DIV_EN
    chk("div_b2b_busy", {31'd0, busy}, 32'd1);
    wait_done("div_m7_2", bc);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);
`else
    chk("div_noop_busy", {31'd0, busy}, 32'd0);
    chk("div_noop_lo", lo, 32'hFFFFFFEB);
    chk("div_noop_hi", hi, 32'hFFFFFFFF);
`endif

    // divide by zero and signed overflow
    run("divu_by0", 3'd3, 32'd100, 32'd0);
`ifdef MDU_DIV_EN
    chk("divu0_lo", lo, 32'hFFFFFFFF);
    chk("divu0_hi", hi, 32'd100);
`endif
    run("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
`ifdef MDU_DIV_EN
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'd0);
`endif

    // MTHI / MTLO on consecutive cycles
    issue(3'd4, 32'h00001234, 32'd0);
    chk("mthi_hi", hi, 32'h00001234);
    issue(3'd5, 32'h00005678, 32'd0);
    chk("mtlo_lo", lo, 32'h00005678);
    chk("mt_busy", {31'd0, busy}, 32'd0);

    // start during busy is ignored
    issue(3'd1, 32'd5, 32'd6);
    issue(3'd4, 32'h0000DEAD, 32'd0);
    chk("ignored_mthi", hi, 32'h00001234);
    wait_done("multu_5_6", bc);
    chk("multu56_lo", lo, 32'd30);
    chk("multu56_hi", hi, 32'd0);

    // abort mid-CALC and during FIX
    issue(3'd4, 32'hAAAA0000, 32'd0);
    issue(3'd5, 32'h0000BBBB, 32'd0);
    issue(3'd0, 32'd3, 32'd4);
    repeat (9) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort10_busy", {31'd0, busy}, 32'd0);
    chk("abort10_hi", hi, 32'hAAAA0000);
    chk("abort10_lo", lo, 32'h0000BBBB);
    repeat (3) @(negedge clk);
    issue(3'd0, 32'd3, 32'd4);
    repeat (32) @(negedge clk);
    chk("fix_busy_pre", {31'd0, busy}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abortfix_busy", {31'd0, busy}, 32'd0);
    chk("abortfix_done", {31'd0, done}, 32'd0);
    chk("abortfix_lo", lo, 32'h0000BBBB);
    repeat (3) @(negedge clk);

    // abort beats a simultaneous start
    abort = 1'b1;
    issue(3'd4, 32'h00000099, 32'd0);
    abort = 1'b0;
    chk("abort_start_hi", hi, 32'hAAAA0000);

    // async reset mid-CALC
    issue(3'd1, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", hi, 32'd0);
    chk("arst_lo", lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MULTU 10*3, then DIVU 10/3
    run("multu_10_3", 3'd1, 32'd10, 32'd3);
    chk("m10x3_lo", lo, 32'd30);
    run("divu_10_3", 3'd3, 32'd10, 32'd3);
`ifdef MDU_DIV_EN
    chk("d10_3_lo", lo, 32'd3);
    chk("d10_3_hi", hi, 32'd1);
`else
    chk("d10_3_noop_lo", lo, 32'd30);
    chk("d10_3_noop_hi", hi, 32'd0);
`endif
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
